// File: rtl/pixel_coord_generator.sv
// pixel_coord_generator: raster-order (x fastest) frame scan source with a valid/ready beat output.
// Optional macro PIXGEN_CONTINUOUS_EN adds a stop port and back-to-back frame looping.
`timescale 1ns/1ps

`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

module pixel_coord_generator #(
    parameter int unsigned SCREEN_WIDTH  = `SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = `SCREEN_HEIGHT,
    parameter int unsigned COORD_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               coords_ready,
`ifdef PIXGEN_CONTINUOUS_EN
    input  logic               stop,
`endif
    output logic [COORD_W-1:0] screen_x,
    output logic [COORD_W-1:0] screen_y,
    output logic               coords_valid,
    output logic               sof,
    output logic               eol,
    output logic               eof,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_HEIGHT - 1);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               frame_done_q, frame_done_d;
`ifdef PIXGEN_CONTINUOUS_EN
    logic               stop_pending_q, stop_pending_d;
`endif

    logic last_x;
    logic last_y;

    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            x_q            <= '0;
            y_q            <= '0;
            frame_done_q   <= 1'b0;
`ifdef PIXGEN_CONTINUOUS_EN
            stop_pending_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            frame_done_q   <= frame_done_d;
`ifdef PIXGEN_CONTINUOUS_EN
            stop_pending_q <= stop_pending_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        frame_done_d   = 1'b0;
`ifdef PIXGEN_CONTINUOUS_EN
        stop_pending_d = stop_pending_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            RUN: begin
`ifdef PIXGEN_CONTINUOUS_EN
                if (stop) stop_pending_d = 1'b1;
`endif
                if (coords_ready) begin
                    if (!last_x) begin
                        x_d = x_q + ONE;
                    end else if (!last_y) begin
                        x_d = '0;
                        y_d = y_q + ONE;
                    end else begin
                        // eof handshake: counters wrap so IDLE and the next frame both start at (0,0)
                        x_d          = '0;
                        y_d          = '0;
                        frame_done_d = 1'b1;
`ifdef PIXGEN_CONTINUOUS_EN
                        if (stop_pending_q || stop) begin
                            state_d        = IDLE;
                            stop_pending_d = 1'b0;
                        end
`else
                        state_d      = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        coords_valid = (state_q == RUN);
        busy         = (state_q == RUN);
        screen_x     = x_q;
        screen_y     = y_q;
        sof          = coords_valid && (x_q == '0) && (y_q == '0);
        eol          = coords_valid && last_x;
        eof          = coords_valid && last_x && last_y;
        frame_done   = frame_done_q;
    end

endmodule

// File: tb/tb_pixel_coord_generator.sv
// Directed bench for pixel_coord_generator on a 4x3 frame: raster order, flags, stalls, resets, restarts.
`timescale 1ns/1ps

module tb_pixel_coord_generator;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          coords_ready = 1'b1;
`ifdef PIXGEN_CONTINUOUS_EN
    logic          stop = 1'b0;
`endif
    logic [CW-1:0] screen_x, screen_y;
    logic          coords_valid, sof, eol, eof, busy, frame_done;

    int pass_cnt  = 0;
    int check_cnt = 0;

    pixel_coord_generator #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .COORD_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .coords_ready(coords_ready),
`ifdef PIXGEN_CONTINUOUS_EN
        .stop        (stop),
`endif
        .screen_x    (screen_x),
        .screen_y    (screen_y),
        .coords_valid(coords_valid),
        .sof         (sof),
        .eol         (eol),
        .eof         (eof),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // {valid, busy, sof, eol, eof, frame_done, x, y}
    logic [6+2*CW-1:0] obs;
    assign obs = {coords_valid, busy, sof, eol, eof, frame_done, screen_x, screen_y};

    // Expected observation while beat k (raster index) is presented.
    function automatic logic [6+2*CW-1:0] beat(input int k, input logic done);
        logic s, l, e;
        s = (k == 0);
        l = ((k % W) == W - 1);
        e = (k == W * H - 1);
        return {1'b1, 1'b1, s, l, e, done, CW'(k % W), CW'(k / W)};
    endfunction

    localparam logic [6+2*CW-1:0] DONE_ONLY = {6'b000001, {(2*CW){1'b0}}};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        check_cnt++;
        if (obs !== '0) $display("FAIL reset_outputs: got %h want %h", obs, {(6+2*CW){1'b0}});
        else pass_cnt++;
        rst = 1'b1;
        tick();
        check_cnt++;
        if (obs !== '0) $display("FAIL idle_after_reset: got %h want %h", obs, {(6+2*CW){1'b0}});
        else pass_cnt++;
    endtask

    task automatic test_frame();
        logic [6+2*CW-1:0] exp;
        coords_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < W * H; k++) begin
            exp = beat(k, 1'b0);
            check_cnt++;
            if (obs !== exp) $display("FAIL frame_beat%0d: got %h want %h", k, obs, exp);
            else pass_cnt++;
            tick();
        end
        check_cnt++;
        if (obs !== DONE_ONLY) $display("FAIL frame_done: got %h want %h", obs, DONE_ONLY);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (obs !== '0) $display("FAIL done_pulse_width: got %h want %h", obs, {(6+2*CW){1'b0}});
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [6+2*CW-1:0] exp;
        coords_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < W * H; k++) begin
            exp = beat(k, 1'b0);
            if (k == 6) begin
                coords_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check_cnt++;
                    if (obs !== exp) $display("FAIL stall%0d_hold: got %h want %h", s, obs, exp);
                    else pass_cnt++;
                    tick();
                end
                coords_ready = 1'b1;
            end
            check_cnt++;
            if (obs !== exp) $display("FAIL bp_beat%0d: got %h want %h", k, obs, exp);
            else pass_cnt++;
            tick();
        end
        check_cnt++;
        if (obs !== DONE_ONLY) $display("FAIL bp_frame_done: got %h want %h", obs, DONE_ONLY);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_start_midframe();
        logic [6+2*CW-1:0] exp;
        coords_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < W * H; k++) begin
            exp = beat(k, 1'b0);
            check_cnt++;
            if (obs !== exp) $display("FAIL mid_start_beat%0d: got %h want %h", k, obs, exp);
            else pass_cnt++;
            start = (k == 5);
            tick();
            start = 1'b0;
        end
        check_cnt++;
        if (obs !== DONE_ONLY) $display("FAIL mid_start_done: got %h want %h", obs, DONE_ONLY);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (obs !== '0) $display("FAIL mid_start_not_queued: got %h want %h", obs, {(6+2*CW){1'b0}});
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [6+2*CW-1:0] exp;
        int seen;
        coords_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            exp = beat(k, 1'b0);
            check_cnt++;
            if (obs !== exp) $display("FAIL pre_rst_beat%0d: got %h want %h", k, obs, exp);
            else pass_cnt++;
            if (k == 6) rst = 1'b0;
            tick();
        end
        rst = 1'b1;
        check_cnt++;
        if (obs !== '0) $display("FAIL midframe_reset: got %h want %h", obs, {(6+2*CW){1'b0}});
        else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (frame_done || coords_valid) seen++;
        end
        check_cnt++;
        if (seen !== 0) $display("FAIL no_done_after_reset: got %0d active cycles want 0", seen);
        else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp = beat(0, 1'b0);
        check_cnt++;
        if (obs !== exp) $display("FAIL restart_after_reset: got %h want %h", obs, exp);
        else pass_cnt++;
        for (int k = 0; k < W * H; k++) tick();
        check_cnt++;
        if (obs !== DONE_ONLY) $display("FAIL restart_done: got %h want %h", obs, DONE_ONLY);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [6+2*CW-1:0] exp;
        coords_ready = 1'b1;
        start = 1'b1;
        tick();
        for (int k = 0; k < W * H; k++) begin
            exp = beat(k, 1'b0);
            check_cnt++;
            if (obs !== exp) $display("FAIL b2b_f1_beat%0d: got %h want %h", k, obs, exp);
            else pass_cnt++;
            tick();
        end
        check_cnt++;
        if (obs !== DONE_ONLY) $display("FAIL b2b_done: got %h want %h", obs, DONE_ONLY);
        else pass_cnt++;
        tick();
        start = 1'b0;
        for (int k = 0; k < W * H; k++) begin
            exp = beat(k, 1'b0);
            check_cnt++;
            if (obs !== exp) $display("FAIL b2b_f2_beat%0d: got %h want %h", k, obs, exp);
            else pass_cnt++;
            tick();
        end
        check_cnt++;
        if (obs !== DONE_ONLY) $display("FAIL b2b_f2_done: got %h want %h", obs, DONE_ONLY);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_random_ready();
        logic [6+2*CW-1:0] exp;
        int e;
        int budget;
        logic r;
        for (int f = 0; f < 3; f++) begin
            coords_ready = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            e = 0;
            budget = 300;
            while (e < W * H && budget > 0) begin
                exp = beat(e, 1'b0);
                check_cnt++;
                if (obs !== exp) $display("FAIL rnd_f%0d_beat%0d: got %h want %h", f, e, obs, exp);
                else pass_cnt++;
                r = 1'($urandom_range(0, 1));
                coords_ready = r;
                tick();
                if (r) e++;
                budget--;
            end
            check_cnt++;
            if (e !== W * H) $display("FAIL rnd_f%0d_timeout: got %0d handshakes want %0d", f, e, W * H);
            else pass_cnt++;
            check_cnt++;
            if (obs !== DONE_ONLY) $display("FAIL rnd_f%0d_done: got %h want %h", f, obs, DONE_ONLY);
            else pass_cnt++;
            tick();
        end
        coords_ready = 1'b1;
    endtask

`ifdef PIXGEN_CONTINUOUS_EN
    task automatic test_continuous();
        logic [6+2*CW-1:0] exp;
        coords_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < W * H; k++) begin
            exp = beat(k, 1'b0);
            check_cnt++;
            if (obs !== exp) $display("FAIL cont_f1_beat%0d: got %h want %h", k, obs, exp);
            else pass_cnt++;
            tick();
        end
        exp = beat(0, 1'b1);
        check_cnt++;
        if (obs !== exp) $display("FAIL cont_wrap: got %h want %h", obs, exp);
        else pass_cnt++;
        for (int k = 1; k < W * H; k++) begin
            tick();
            stop = 1'b0;
            exp = beat(k, 1'b0);
            check_cnt++;
            if (obs !== exp) $display("FAIL cont_f2_beat%0d: got %h want %h", k, obs, exp);
            else pass_cnt++;
            if (k == 3) stop = 1'b1;
        end
        tick();
        check_cnt++;
        if (obs !== DONE_ONLY) $display("FAIL cont_stop_done: got %h want %h", obs, DONE_ONLY);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (obs !== '0) $display("FAIL cont_idle: got %h want %h", obs, {(6+2*CW){1'b0}});
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_start_midframe();
        test_reset_midframe();
        test_back_to_back();
        test_random_ready();
`ifdef PIXGEN_CONTINUOUS_EN
        test_continuous();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
